sevseg_scan: RTL and testbench

- Two-digit multiplexed seven-segment display driver that sits directly downstream of the memory-mapped I/O block.
- Consumes the two 4-bit display nibbles that block latches from address 31 (low nibble = hex_lo, high nibble = hex_hi) and drives a shared common-anode display.
- Snapshots the nibbles once per refresh frame, hex-decodes them, and time-multiplexes the two digits with an anti-ghosting blank gap.
- Optionally blanks the leading zero and flashes the display for a few frames after a value change.

---
 rtl/sevseg_scan.sv | 142 ++++++++++++++
 tb/tb_sevseg_scan.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevseg_scan.sv
// Two-digit multiplexed common-anode seven-segment driver.
// Snapshots the display nibbles once per frame and scans both digits with blanking gaps.
module sevseg_scan #(
    parameter int REFRESH_DIV  = 50000,
    parameter int GAP_CYCLES   = 500,
    parameter int BLANK_LZ     = 1,
    parameter int FLASH_FRAMES = 8
) (
    input  logic       clock,
    input  logic       n_reset,
    input  logic [3:0] hex_lo,
    input  logic [3:0] hex_hi,
    input  logic       enable,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       dp,
    output logic       frame_tick
);

    localparam int MAX_LEN = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_LEN) + 1;
    localparam int FW      = (FLASH_FRAMES > 0) ? $clog2(FLASH_FRAMES + 1) : 1;

    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [FW-1:0] FLASH_INIT = FW'(FLASH_FRAMES);

    typedef enum logic [2:0] {
        S_LOAD,
        S_SHOW0,
        S_GAP0,
        S_SHOW1,
        S_GAP1
    } state_t;

    state_t        r_state, w_state_next, w_step;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [3:0]    r_sh_lo, r_sh_hi, w_sh_lo_next, w_sh_hi_next;
    logic [FW-1:0] r_flash, w_flash_next;
    logic [6:0]    r_seg, w_seg_next;
    logic [1:0]    r_an, w_an_next;
    logic          r_tick;
    logic          w_last;
    logic          w_lit;

    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    always_comb begin
        w_last = 1'b0;
        w_step = S_LOAD;
        case (r_state)
            S_LOAD:  begin w_last = 1'b1;                 w_step = S_SHOW0; end
            S_SHOW0: begin w_last = (r_cnt == SHOW_LAST); w_step = S_GAP0;  end
            S_GAP0:  begin w_last = (r_cnt == GAP_LAST);  w_step = S_SHOW1; end
            S_SHOW1: begin w_last = (r_cnt == SHOW_LAST); w_step = S_GAP1;  end
            S_GAP1:  begin w_last = (r_cnt == GAP_LAST);  w_step = S_LOAD;  end
            default: begin w_last = 1'b1;                 w_step = S_LOAD;  end
        endcase
        w_state_next = w_last ? w_step : r_state;
        w_cnt_next   = w_last ? '0 : r_cnt + CW'(1);
    end

    // Snapshot and flash bookkeeping happen only on the LOAD cycle, so a frame never tears.
    always_comb begin
        w_sh_lo_next = r_sh_lo;
        w_sh_hi_next = r_sh_hi;
        w_flash_next = r_flash;
        if (r_state == S_LOAD) begin
            w_sh_lo_next = hex_lo;
            w_sh_hi_next = hex_hi;
            if (FLASH_FRAMES != 0 && {hex_hi, hex_lo} != {r_sh_hi, r_sh_lo}) begin
                w_flash_next = FLASH_INIT;
            end else if (r_flash != '0) begin
                w_flash_next = r_flash - FW'(1);
            end
        end
    end

    // Outputs are decoded from next-cycle values so an/seg line up with the state register.
    always_comb begin
        w_lit      = enable & ~w_flash_next[0];
        w_an_next  = 2'b11;
        w_seg_next = 7'h7F;
        if (w_lit) begin
            if (w_state_next == S_SHOW0) begin
                w_an_next  = 2'b10;
                w_seg_next = ~dec(w_sh_lo_next);
            end else if (w_state_next == S_SHOW1 &&
                         !(BLANK_LZ != 0 && w_sh_hi_next == 4'h0)) begin
                w_an_next  = 2'b01;
                w_seg_next = ~dec(w_sh_hi_next);
            end
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
            r_sh_lo <= '0;
            r_sh_hi <= '0;
            r_flash <= '0;
            r_an    <= 2'b11;
            r_seg   <= 7'h7F;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_sh_lo <= w_sh_lo_next;
            r_sh_hi <= w_sh_hi_next;
            r_flash <= w_flash_next;
            r_an    <= w_an_next;
            r_seg   <= w_seg_next;
            r_tick  <= (w_state_next == S_LOAD);
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign dp         = 1'b1;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_sevseg_scan.sv
// Bench for sevseg_scan: two instances (plain, and leading-zero blank + flash)
// compared against a frame-position reference model and fixed expected values.
module tb_sevseg_scan;

    localparam int R     = 4;
    localparam int G     = 2;
    localparam int FRAME = 1 + 2 * R + 2 * G;

    logic       clock = 1'b0;
    logic       n_reset = 1'b0;
    logic [3:0] hex_lo = 4'h0;
    logic [3:0] hex_hi = 4'h0;
    logic       enable = 1'b1;
    logic [6:0] seg0, seg1;
    logic [1:0] an0, an1;
    logic       dp0, dp1, tick0, tick1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    sevseg_scan #(.REFRESH_DIV(R), .GAP_CYCLES(G), .BLANK_LZ(0), .FLASH_FRAMES(0)) u_base (
        .clock(clock), .n_reset(n_reset), .hex_lo(hex_lo), .hex_hi(hex_hi), .enable(enable),
        .seg(seg0), .an(an0), .dp(dp0), .frame_tick(tick0));

    sevseg_scan #(.REFRESH_DIV(R), .GAP_CYCLES(G), .BLANK_LZ(1), .FLASH_FRAMES(4)) u_opt (
        .clock(clock), .n_reset(n_reset), .hex_lo(hex_lo), .hex_hi(hex_hi), .enable(enable),
        .seg(seg1), .an(an1), .dp(dp1), .frame_tick(tick1));

    // ---------------- reference model ----------------
    logic [6:0] dec_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int         p_ff [2] = '{0, 4};
    int         p_lz [2] = '{0, 1};

    int         m_pos = 0;
    logic       m_tick = 1'b0;
    logic [7:0] m_sh  [2] = '{8'h00, 8'h00};
    int         m_fl  [2] = '{0, 0};
    logic [1:0] m_an  [2] = '{2'b11, 2'b11};
    logic [6:0] m_seg [2] = '{7'h7F, 7'h7F};

    function automatic int f_flash(input int ff, input int fl, input int pos,
                                   input logic [7:0] sh, input logic [7:0] din);
        if (pos != 0) return fl;
        if (ff != 0 && din != sh) return ff;
        if (fl > 0) return fl - 1;
        return fl;
    endfunction

    // Returns {an, seg} for frame position pos.
    function automatic logic [8:0] f_disp(input int lz, input int pos, input logic [7:0] sh,
                                          input int fl, input logic en);
        if (en && (fl % 2 == 0)) begin
            if (pos >= 1 && pos <= R)
                return {2'b10, ~dec_tbl[sh[3:0]]};
            if (pos >= R + G + 1 && pos <= 2 * R + G && !(lz != 0 && sh[7:4] == 4'h0))
                return {2'b01, ~dec_tbl[sh[7:4]]};
        end
        return {2'b11, 7'h7F};
    endfunction

    always @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            m_pos  <= 0;
            m_tick <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_sh[i]  <= 8'h00;
                m_fl[i]  <= 0;
                m_an[i]  <= 2'b11;
                m_seg[i] <= 7'h7F;
            end
        end else begin
            m_pos  <= (m_pos + 1) % FRAME;
            m_tick <= ((m_pos + 1) % FRAME == 0);
            for (int i = 0; i < 2; i++) begin
                m_sh[i] <= (m_pos == 0) ? {hex_hi, hex_lo} : m_sh[i];
                m_fl[i] <= f_flash(p_ff[i], m_fl[i], m_pos, m_sh[i], {hex_hi, hex_lo});
                {m_an[i], m_seg[i]} <= f_disp(p_lz[i], (m_pos + 1) % FRAME,
                    (m_pos == 0) ? {hex_hi, hex_lo} : m_sh[i],
                    f_flash(p_ff[i], m_fl[i], m_pos, m_sh[i], {hex_hi, hex_lo}), enable);
            end
        end
    end

    // Two anodes low at once would short-drive both digits.
    always @(negedge clock) begin
        n_tests++;
        if (an0 === 2'b00 || an1 === 2'b00) begin
            n_fail++;
            $display("FAIL an_overlap: an0=%b an1=%b required never 00", an0, an1);
        end
    end

    task automatic wait_pos(input int p);
        int k;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (m_pos != p && k < 2 * FRAME);
        if (m_pos != p) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_pos: pos=%0d required %0d", m_pos, p);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_reset = 1'b0;
        repeat (3) @(negedge clock);
        n_tests++;
        if ({an0, seg0, dp0, tick0} !== {2'b11, 7'h7F, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_base: an=%b seg=%h dp=%b tick=%b required 11 7f 1 0", an0, seg0, dp0, tick0);
        end
        n_tests++;
        if ({an1, seg1, dp1, tick1} !== {2'b11, 7'h7F, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_opt: an=%b seg=%h dp=%b tick=%b required 11 7f 1 0", an1, seg1, dp1, tick1);
        end
        hex_hi  = 4'h4;
        hex_lo  = 4'h2;
        n_reset = 1'b1;
        $display("[TB] reset released, hex=42");
    endtask

    task automatic test_scan();
        int last_tick;
        last_tick = -1;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clock);
            n_tests++;
            if ({an0, seg0, tick0} !== {m_an[0], m_seg[0], m_tick}) begin
                n_fail++;
                $display("FAIL scan_model: pos=%0d an=%b seg=%h tick=%b required %b %h %b",
                         m_pos, an0, seg0, tick0, m_an[0], m_seg[0], m_tick);
            end
            if (m_pos == 1) begin
                n_tests++;
                if ({an0, seg0} !== {2'b10, 7'h24}) begin
                    n_fail++;
                    $display("FAIL scan_show0: an=%b seg=%h required 10 24", an0, seg0);
                end
            end
            if (m_pos == R + G + 1) begin
                n_tests++;
                if ({an0, seg0} !== {2'b01, 7'h19}) begin
                    n_fail++;
                    $display("FAIL scan_show1: an=%b seg=%h required 01 19", an0, seg0);
                end
            end
            if (tick0 === 1'b1) begin
                if (last_tick >= 0) begin
                    n_tests++;
                    if (c - last_tick != FRAME) begin
                        n_fail++;
                        $display("FAIL tick_period: period=%0d required %0d", c - last_tick, FRAME);
                    end
                end
                last_tick = c;
            end
        end
        $display("[TB] scan of 42 over two frames checked");
    endtask

    task automatic test_change_midframe();
        wait_pos(2);
        hex_lo = 4'h9;
        for (int c = 0; c < FRAME - 3; c++) begin
            @(negedge clock);
            if (m_pos == 3 || m_pos == 4 || m_pos == R + G + 1) begin
                n_tests++;
                if (seg0 !== ((m_pos == R + G + 1) ? 7'h19 : 7'h24)) begin
                    n_fail++;
                    $display("FAIL no_tear: pos=%0d seg=%h required old value", m_pos, seg0);
                end
            end
        end
        wait_pos(1);
        n_tests++;
        if ({an0, seg0} !== {2'b10, 7'h10}) begin
            n_fail++;
            $display("FAIL new_lo: an=%b seg=%h required 10 10", an0, seg0);
        end
        $display("[TB] mid-frame change 42->49 checked");
    endtask

    task automatic test_blank_lz();
        hex_hi = 4'h0;
        hex_lo = 4'hA;
        repeat (6 * FRAME) @(negedge clock);
        wait_pos(1);
        n_tests++;
        if ({an1, seg1} !== {2'b10, 7'h08}) begin
            n_fail++;
            $display("FAIL lz_show0: an=%b seg=%h required 10 08", an1, seg1);
        end
        wait_pos(R + G + 1);
        for (int c = 0; c < R; c++) begin
            n_tests++;
            if ({an1, seg1} !== {2'b11, 7'h7F}) begin
                n_fail++;
                $display("FAIL lz_show1: an=%b seg=%h required 11 7f", an1, seg1);
            end
            if (c == 0) begin
                n_tests++;
                if ({an0, seg0} !== {2'b01, 7'h40}) begin
                    n_fail++;
                    $display("FAIL nolz_show1: an=%b seg=%h required 01 40", an0, seg0);
                end
            end
            @(negedge clock);
        end
        $display("[TB] leading-zero blanking with hex=0A checked");
    endtask

    task automatic test_flash();
        int cnt;
        logic lit;
        hex_hi = 4'h0;
        hex_lo = 4'h0;
        repeat (6 * FRAME) @(negedge clock);
        wait_pos(3);
        hex_hi = 4'h3;
        hex_lo = 4'hC;
        for (int k = 0; k < 6; k++) begin
            cnt = (k < 4) ? 4 - k : 0;
            lit = (cnt % 2 == 0);
            wait_pos(1);
            n_tests++;
            if ({an1, seg1} !== (lit ? {2'b10, 7'h46} : {2'b11, 7'h7F})) begin
                n_fail++;
                $display("FAIL flash_show0: frame=%0d an=%b seg=%h required lit=%b", k, an1, seg1, lit);
            end
            wait_pos(R + G + 1);
            n_tests++;
            if ({an1, seg1} !== (lit ? {2'b01, 7'h30} : {2'b11, 7'h7F})) begin
                n_fail++;
                $display("FAIL flash_show1: frame=%0d an=%b seg=%h required lit=%b", k, an1, seg1, lit);
            end
            $display("[TB] flash frame %0d flash_cnt=%0d lit=%b", k, cnt, lit);
        end
    endtask

    task automatic test_enable();
        int ticks;
        hex_hi = 4'h7;
        hex_lo = 4'hF;
        repeat (FRAME) @(negedge clock);
        wait_pos(FRAME - 1);
        enable = 1'b0;
        ticks  = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clock);
            if (tick0 === 1'b1) ticks++;
            n_tests++;
            if ({an0, seg0} !== {2'b11, 7'h7F}) begin
                n_fail++;
                $display("FAIL disabled_blank: pos=%0d an=%b seg=%h required 11 7f", m_pos, an0, seg0);
            end
        end
        n_tests++;
        if (ticks != 2) begin
            n_fail++;
            $display("FAIL disabled_ticks: ticks=%0d required 2", ticks);
        end
        enable = 1'b1;
        wait_pos(1);
        n_tests++;
        if ({an0, seg0} !== {2'b10, 7'h0E}) begin
            n_fail++;
            $display("FAIL reenable_show0: an=%b seg=%h required 10 0e", an0, seg0);
        end
        wait_pos(R + G + 1);
        n_tests++;
        if ({an0, seg0} !== {2'b01, 7'h78}) begin
            n_fail++;
            $display("FAIL reenable_show1: an=%b seg=%h required 01 78", an0, seg0);
        end
        $display("[TB] enable off for two frames then on, hex=7F checked");
    endtask

    task automatic test_reset_midframe();
        wait_pos(R + G + 2);
        #2 n_reset = 1'b0;
        #1;
        n_tests++;
        if ({an0, seg0, tick0, an1, seg1, tick1} !== {2'b11, 7'h7F, 1'b0, 2'b11, 7'h7F, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: an0=%b seg0=%h tick0=%b an1=%b seg1=%h tick1=%b required blank",
                     an0, seg0, tick0, an1, seg1, tick1);
        end
        @(negedge clock);
        @(negedge clock);
        n_reset = 1'b1;
        @(negedge clock);
        n_tests++;
        if ({an0, seg0, tick0} !== {2'b10, 7'h0E, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_resume: an=%b seg=%h tick=%b required 10 0e 0", an0, seg0, tick0);
        end
        n_tests++;
        if ({an1, seg1} !== {m_an[1], m_seg[1]}) begin
            n_fail++;
            $display("FAIL reset_resume_opt: an=%b seg=%h required %b %h", an1, seg1, m_an[1], m_seg[1]);
        end
        $display("[TB] reset asserted during SHOW1 and released checked");
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int c = 0; c < 20 * FRAME; c++) begin
            @(negedge clock);
            n_tests++;
            if ({an0, seg0, tick0, dp0} !== {m_an[0], m_seg[0], m_tick, 1'b1}) begin
                n_fail++;
                bad++;
                $display("FAIL rand_base: pos=%0d an=%b seg=%h tick=%b dp=%b required %b %h %b 1",
                         m_pos, an0, seg0, tick0, dp0, m_an[0], m_seg[0], m_tick);
            end
            n_tests++;
            if ({an1, seg1, tick1, dp1} !== {m_an[1], m_seg[1], m_tick, 1'b1}) begin
                n_fail++;
                bad++;
                $display("FAIL rand_opt: pos=%0d an=%b seg=%h tick=%b dp=%b required %b %h %b 1",
                         m_pos, an1, seg1, tick1, dp1, m_an[1], m_seg[1], m_tick);
            end
            if ($urandom_range(0, 15) == 0) begin
                hex_lo = 4'($urandom_range(0, 15));
                hex_hi = 4'($urandom_range(0, 15));
            end
            enable = ($urandom_range(0, 7) != 0);
        end
        enable = 1'b1;
        $display("[TB] random stimulus over %0d frames, %0d mismatching cycles", 20, bad);
    endtask

    initial begin
        test_reset();
        test_scan();
        test_change_midframe();
        test_blank_lz();
        test_flash();
        test_enable();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
